// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit and its neighbours.
package ifu_pkg;

  // Bus widths shared with decode.
  localparam int unsigned IFU_ADDR_W = 32;
  localparam int unsigned IFU_INST_W = 32;

  // Default first fetch address after reset.
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StErr
  } ifu_state_e;

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bus bundle: imem request/response, decode handoff and redirect input.
interface ifu_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
) ();

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              imem_resp_err;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_id;
  logic [ADDR_W-1:0] pc_id;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              fetch_err;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_id, pc_id, fetch_err,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  inst_ready, redirect_valid, redirect_pc
  );

  // Memory / decode / branch-resolution side.
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_id, pc_id, fetch_err,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output inst_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time, hands the
// fetched instruction to decode and honours control-flow redirects.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IFU_ADDR_W,
  parameter int unsigned       INST_W   = IFU_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic clk,
  input  logic rst,
  ifu_if.master bus
);

  ifu_state_e        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_addr;   // address of the request being presented
  logic              r_kill;       // outstanding response belongs to a dead path
  logic [INST_W-1:0] r_inst_id;
  logic [ADDR_W-1:0] r_pc_id;
  logic              r_fetch_err;

  logic [ADDR_W-1:0] w_redirect_pc;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_req_fire;

  // Redirect targets are word-aligned; low bits are dropped.
  assign w_redirect_pc = bus.redirect_pc & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  assign w_pc_inc      = r_pc + ADDR_W'(4);
  assign w_req_fire    = (r_state == StReq) && bus.imem_req_ready;

  assign bus.imem_req_valid = (r_state == StReq);
  assign bus.inst_valid     = (r_state == StHold);
  assign bus.imem_req_addr  = r_req_addr;
  assign bus.inst_id        = r_inst_id;
  assign bus.pc_id          = r_pc_id;
  assign bus.fetch_err      = r_fetch_err;

  // Fetch FSM plus PC, kill flag and decode-side holding registers.
  // r_req_addr is latched on entry to StReq so a redirect that arrives while the
  // request is stalled cannot disturb the address memory is looking at; the stale
  // request completes and its response is dropped via r_kill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_kill      <= 1'b0;
      r_inst_id   <= INST_W'(ZERO_WORD);
      r_pc_id     <= ADDR_W'(ZERO_WORD);
      r_fetch_err <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_state    <= StReq;
          r_req_addr <= r_pc;
        end

        StReq: begin
          if (w_req_fire) begin
            r_state <= StWait;
          end
          if (bus.redirect_valid) begin
            r_pc   <= w_redirect_pc;
            r_kill <= 1'b1;
          end
        end

        StWait: begin
          if (bus.imem_resp_valid) begin
            if (r_kill || bus.redirect_valid) begin
              // Dead-path response (error included): refetch on the new path.
              r_kill     <= 1'b0;
              r_state    <= StReq;
              r_pc       <= bus.redirect_valid ? w_redirect_pc : r_pc;
              r_req_addr <= bus.redirect_valid ? w_redirect_pc : r_pc;
            end else if (bus.imem_resp_err) begin
              r_fetch_err <= 1'b1;
              r_state     <= StErr;
            end else begin
              r_inst_id <= bus.imem_resp_data;
              r_pc_id   <= r_pc;
              r_pc      <= w_pc_inc;
              r_state   <= StHold;
            end
          end else if (bus.redirect_valid) begin
            r_pc   <= w_redirect_pc;
            r_kill <= 1'b1;
          end
        end

        StHold: begin
          // Redirect beats the handshake; the held instruction is dropped either way.
          if (bus.redirect_valid) begin
            r_pc       <= w_redirect_pc;
            r_req_addr <= w_redirect_pc;
            r_state    <= StReq;
          end else if (bus.inst_ready) begin
            r_req_addr <= r_pc;
            r_state    <= StReq;
          end
        end

        StErr: begin
          r_state <= StErr;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
